// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode pipeline register built as a small in-order FIFO with a
// valid/ready handshake toward decode and a flush for wrong-path instructions.
module fetch_decode_buffer #(
    parameter int               WIDTH = 32,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] NOP   = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_F,
    output logic                       ready_F,
    input  logic [WIDTH-1:0]           instr_F,
    input  logic [WIDTH-1:0]           PC_F,
    input  logic [WIDTH-1:0]           PCPlus4_F,
    input  logic                       flush_D,
    output logic                       valid_D,
    input  logic                       ready_D,
    output logic [WIDTH-1:0]           instr_D,
    output logic [WIDTH-1:0]           PC_D,
    output logic [WIDTH-1:0]           PCPlus4_D,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [3*WIDTH-1:0] mem_q [DEPTH];
    logic [3*WIDTH-1:0] head;
    logic               push, pop;

    // ready_F looks only at occupancy, so a pop never passes through to fetch
    always_comb begin
        ready_F  = (count_q != CW'(DEPTH));
        valid_D  = (count_q != '0);
        push     = valid_F & ready_F & ~flush_D;
        pop      = valid_D & ready_D & ~flush_D;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_D) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        instr_D   = NOP;
        PC_D      = '0;
        PCPlus4_D = '0;
        if (valid_D) begin
            instr_D   = head[3*WIDTH-1:2*WIDTH];
            PC_D      = head[2*WIDTH-1:WIDTH];
            PCPlus4_D = head[WIDTH-1:0];
        end
    end

    assign count = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; entries are only observable while counted
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {instr_F, PC_F, PCPlus4_F};
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_fetch_decode_buffer;

    localparam int        DEPTH   = 2;
    localparam logic [31:0] NOP_I = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        valid_F;
    logic        ready_F;
    logic [31:0] instr_F;
    logic [31:0] PC_F;
    logic [31:0] PCPlus4_F;
    logic        flush_D;
    logic        valid_D;
    logic        ready_D;
    logic [31:0] instr_D;
    logic [31:0] PC_D;
    logic [31:0] PCPlus4_D;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
    } entry_t;

    entry_t model_q[$];

    fetch_decode_buffer #(.WIDTH(32), .DEPTH(DEPTH), .NOP(NOP_I)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_F   (valid_F),
        .ready_F   (ready_F),
        .instr_F   (instr_F),
        .PC_F      (PC_F),
        .PCPlus4_F (PCPlus4_F),
        .flush_D   (flush_D),
        .valid_D   (valid_D),
        .ready_D   (ready_D),
        .instr_D   (instr_D),
        .PC_D      (PC_D),
        .PCPlus4_D (PCPlus4_D),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare every DUT output against the model's view of the buffer
    task automatic checkAll();
        logic [31:0] exp_instr, exp_pc, exp_pcp4;
        exp_instr = NOP_I;
        exp_pc    = 32'h0;
        exp_pcp4  = 32'h0;
        if (model_q.size() != 0) begin
            exp_instr = model_q[0].instr;
            exp_pc    = model_q[0].pc;
            exp_pcp4  = model_q[0].pcp4;
        end
        checkOutput("ready_F", {31'b0, ready_F}, {31'b0, model_q.size() != DEPTH});
        checkOutput("valid_D", {31'b0, valid_D}, {31'b0, model_q.size() != 0});
        checkOutput("instr_D", instr_D, exp_instr);
        checkOutput("PC_D", PC_D, exp_pc);
        checkOutput("PCPlus4_D", PCPlus4_D, exp_pcp4);
        checkOutput("count", {30'b0, count}, model_q.size());
    endtask

    // Drive one cycle of inputs (called just after a falling edge), check the
    // combinational view before the rising edge, then advance the model
    task automatic applyStimulus(input bit r, input bit v, input bit rdy, input bit fl,
                                 input logic [31:0] ins, input logic [31:0] pc);
        entry_t e;
        bit do_push, do_pop;
        rst       = r;
        valid_F   = v;
        ready_D   = rdy;
        flush_D   = fl;
        instr_F   = ins;
        PC_F      = pc;
        PCPlus4_F = pc + 32'd4;
        #1;
        if (!r) model_q.delete();
        checkAll();
        @(posedge clk);
        if (r) begin
            do_push = v && (model_q.size() != DEPTH) && !fl;
            do_pop  = (model_q.size() != 0) && rdy && !fl;
            if (fl) begin
                model_q.delete();
            end else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    e.instr = ins;
                    e.pc    = pc;
                    e.pcp4  = pc + 32'd4;
                    model_q.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        valid_F   = 1'b0;
        ready_D   = 1'b0;
        flush_D   = 1'b0;
        instr_F   = 32'h0;
        PC_F      = 32'h0;
        PCPlus4_F = 32'h4;
        @(negedge clk);

        // Reset held with fetch valid: nothing may enter
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        // Streaming with decode always ready
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h00100093 + i, 32'h0 + 4*i);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        // Stall until full, then drain while 0x18 keeps knocking
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h00200093 + i, 32'h10 + 4*i);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h00200095, 32'h18);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        // Flush with a full buffer and a fetch beat in flight
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h00300093, 32'h20);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h00300094, 32'h24);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h00300095, 32'h28);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h00400093, 32'h40);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        // Randomized traffic across many pointer wraps
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 19) == 0), $urandom, 32'h1000 + 4*i);

        // Mid-operation reset: fill, then drop rst between edges
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h00600093, 32'h80);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h00600094, 32'h84);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h00700093, 32'h90);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
